// File: rtl/noc_axi4_bridge_deser_pp.sv
// noc_axi4_bridge_deser_pp: double-buffered NoC-to-AXI deserializer collecting header and payload flits
// into ping-pong slots with zero-fill, oversize/undersize detection and optional byte swap.
module noc_axi4_bridge_deser_pp #(
    parameter int NOC_W          = 64,
    parameter int AXI_W          = 512,
    parameter int HDR_FLITS      = 3,
    parameter int LEN_W          = 8,
    parameter int LEN_LSB        = 22,
    parameter int DESER_ORDER    = 0,
    parameter int SWAP_ENDIANESS = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NOC_W-1:0]           flit_in,
    input  logic                       flit_in_val,
    output logic                       flit_in_rdy,
    input  logic                       phy_init_done,
    output logic [HDR_FLITS*NOC_W-1:0] header_out,
    output logic [AXI_W-1:0]           data_out,
    output logic [LEN_W-1:0]           payload_cnt,
    output logic                       pkt_err,
    output logic                       out_val,
    input  logic                       out_rdy
);
    localparam int PAYLOAD = AXI_W / NOC_W;
    localparam int HW = HDR_FLITS * NOC_W;

    typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

    state_t           state;
    logic [HW-1:0]    hdr_q  [2];
    logic [AXI_W-1:0] data_q [2];
    logic [LEN_W-1:0] cnt_q  [2];
    logic [1:0]       err_q, full_q;
    logic             wr_ptr, rd_ptr;
    logic [LEN_W-1:0] remaining, rem_eff, lane;
    logic [2:0]       hidx;
    logic             acc, pop, first, last, cnt_full;
    logic [NOC_W-1:0] sw;

    assign flit_in_rdy = phy_init_done & ~full_q[wr_ptr];
    assign acc         = flit_in_val & flit_in_rdy;
    assign out_val     = full_q[rd_ptr];
    assign pop         = out_val & out_rdy;
    assign header_out  = hdr_q[rd_ptr];
    assign data_out    = data_q[rd_ptr];
    assign payload_cnt = cnt_q[rd_ptr];
    assign pkt_err     = err_q[rd_ptr];

    // The length field counts the flits that follow the first one, so the first flit uses it directly.
    assign first    = (state == HDR) && (hidx == 3'd0);
    assign rem_eff  = first ? flit_in[LEN_LSB +: LEN_W] : remaining;
    assign last     = (rem_eff == '0);
    assign cnt_full = (cnt_q[wr_ptr] == LEN_W'(PAYLOAD));
    assign lane     = (DESER_ORDER != 0) ? LEN_W'(PAYLOAD - 1) - cnt_q[wr_ptr] : cnt_q[wr_ptr];

    always_comb begin
        sw = flit_in;
        if (SWAP_ENDIANESS != 0)
            for (int b = 0; b < NOC_W / 8; b++)
                sw[b*8 +: 8] = flit_in[NOC_W-8-b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HDR;
            hidx      <= '0;
            remaining <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            full_q    <= '0;
            err_q     <= '0;
            for (int s = 0; s < 2; s++) begin
                hdr_q[s]  <= '0;
                data_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
        end else begin
            if (pop) begin
                full_q[rd_ptr] <= 1'b0;
                rd_ptr         <= ~rd_ptr;
            end
            if (acc) begin
                remaining <= rem_eff - LEN_W'(1);
                if (last) begin
                    full_q[wr_ptr] <= 1'b1;
                    wr_ptr         <= ~wr_ptr;
                    state          <= HDR;
                    hidx           <= '0;
                end
                case (state)
                    HDR: begin
                        if (first) begin
                            hdr_q[wr_ptr]  <= HW'(flit_in);
                            data_q[wr_ptr] <= '0;
                            cnt_q[wr_ptr]  <= '0;
                        end else begin
                            for (int k = 1; k < HDR_FLITS; k++)
                                if (k == int'(hidx)) hdr_q[wr_ptr][k*NOC_W +: NOC_W] <= flit_in;
                        end
                        err_q[wr_ptr] <= last && (hidx != 3'(HDR_FLITS - 1));
                        if (!last) begin
                            if (hidx == 3'(HDR_FLITS - 1)) begin
                                state <= DATA;
                                hidx  <= '0;
                            end else begin
                                hidx <= hidx + 3'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt_full) begin
                            err_q[wr_ptr] <= 1'b1;
                            if (!last) state <= DROP;
                        end else begin
                            for (int p = 0; p < PAYLOAD; p++)
                                if (p == int'(lane)) data_q[wr_ptr][p*NOC_W +: NOC_W] <= sw;
                            cnt_q[wr_ptr] <= cnt_q[wr_ptr] + LEN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_noc_axi4_bridge_deser_pp.sv
// tb_noc_axi4_bridge_deser_pp: scoreboard bench; expected packets are queued at send time and
// popped by per-instance monitors whenever the DUT hands a packet over.
module tb_noc_axi4_bridge_deser_pp;
    typedef struct packed {
        logic [191:0] hdr;
        logic [511:0] data;
        logic [7:0]   cnt;
        logic         err;
    } pkt_t;

    logic clk = 1'b0, rst_n = 1'b0, phy = 1'b1;
    logic [63:0]  f_a = '0, f_b = '0;
    logic         v_a = 1'b0, v_b = 1'b0, ordy_a = 1'b1, ordy_b = 1'b1;
    logic         rdy_a, rdy_b, oval_a, oval_b, err_a, err_b;
    logic [191:0] hdr_a, hdr_b;
    logic [511:0] data_a, data_b;
    logic [7:0]   cnt_a, cnt_b;
    pkt_t q_a[$], q_b[$];
    int errors = 0, checks = 0;
    logic [63:0] fl[16];

    always #5 clk = ~clk;

    noc_axi4_bridge_deser_pp u_a (
        .clk(clk), .rst_n(rst_n), .flit_in(f_a), .flit_in_val(v_a), .flit_in_rdy(rdy_a),
        .phy_init_done(phy), .header_out(hdr_a), .data_out(data_a), .payload_cnt(cnt_a),
        .pkt_err(err_a), .out_val(oval_a), .out_rdy(ordy_a)
    );

    noc_axi4_bridge_deser_pp #(.DESER_ORDER(1), .SWAP_ENDIANESS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .flit_in(f_b), .flit_in_val(v_b), .flit_in_rdy(rdy_b),
        .phy_init_done(phy), .header_out(hdr_b), .data_out(data_b), .payload_cnt(cnt_b),
        .pkt_err(err_b), .out_val(oval_b), .out_rdy(ordy_b)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_h0(input logic [7:0] len, input logic [15:0] tag);
        return {tag, 18'h0, len, 22'h1};
    endfunction

    function automatic logic [511:0] mk_data(input logic [63:0] base, input int n);
        mk_data = '0;
        for (int i = 0; i < n; i++) mk_data[i*64 +: 64] = base + 64'(i);
    endfunction

    function automatic logic [191:0] mk_hdr(input logic [7:0] len, input logic [15:0] tag);
        return {{tag, 48'h2}, {tag, 48'h1}, mk_h0(len, tag)};
    endfunction

    task automatic load(input logic [7:0] len, input logic [15:0] tag, input logic [63:0] pb, input int np);
        fl[0] = mk_h0(len, tag);
        fl[1] = {tag, 48'h1};
        fl[2] = {tag, 48'h2};
        for (int i = 0; i < np; i++) fl[3+i] = pb + 64'(i);
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Called at a negedge; each flit is held until flit_in_rdy is seen high, then one edge passes.
    task automatic send(input bit b, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int t = 0;
            if (b) begin f_b = fl[i]; v_b = 1'b1; end
            else   begin f_a = fl[i]; v_a = 1'b1; end
            while (!(b ? rdy_b : rdy_a)) begin
                @(negedge clk);
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: flit %0d never accepted, required acceptance within 200 cycles", i);
                    finish_run();
                end
            end
            @(negedge clk);
        end
        v_a = 1'b0;
        v_b = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_a", 512'(q_a.size()), 512'd0);
        chk("drain_b", 512'(q_b.size()), 512'd0);
    endtask

    initial begin : mon_a
        pkt_t e;
        forever begin
            @(negedge clk);
            #1;
            if (oval_a && ordy_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: got packet hdr %0h, required no packet", hdr_a);
                end else begin
                    e = q_a.pop_front();
                    chk("a_header", 512'(hdr_a), 512'(e.hdr));
                    chk("a_data", data_a, e.data);
                    chk("a_cnt", 512'(cnt_a), 512'(e.cnt));
                    chk("a_err", 512'(err_a), 512'(e.err));
                end
            end
        end
    end

    initial begin : mon_b
        pkt_t e;
        forever begin
            @(negedge clk);
            #1;
            if (oval_b && ordy_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got packet hdr %0h, required no packet", hdr_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_header", 512'(hdr_b), 512'(e.hdr));
                    chk("b_data", data_b, e.data);
                    chk("b_cnt", 512'(cnt_b), 512'(e.cnt));
                    chk("b_err", 512'(err_b), 512'(e.err));
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_val", 512'(oval_a), 512'd0);
        chk("rst_header", 512'(hdr_a), 512'd0);
        chk("rst_data", data_a, 512'd0);
        chk("rst_cnt", 512'(cnt_a), 512'd0);
        chk("rst_err", 512'(err_a), 512'd0);
        chk("rst_rdy_phy1", 512'(rdy_a), 512'd1);
        phy = 1'b0;
        #1;
        chk("rdy_phy0", 512'(rdy_a), 512'd0);
        @(negedge clk);
        phy = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal 11-flit packet, latency from last flit to out_val
        load(8'd10, 16'hA1, 64'h10, 8);
        q_a.push_back({mk_hdr(8'd10, 16'hA1), mk_data(64'h10, 8), 8'd8, 1'b0});
        send(0, 0, 9);
        chk("pre_last_out_val", 512'(oval_a), 512'd0);
        send(0, 10, 10);
        chk("latency_out_val", 512'(oval_a), 512'd1);

        // Short packet: two payload flits, remaining lanes zero
        load(8'd4, 16'hB2, 64'h0, 0);
        fl[3] = 64'hAA;
        fl[4] = 64'hBB;
        q_a.push_back({mk_hdr(8'd4, 16'hB2), {384'h0, 64'hBB, 64'hAA}, 8'd2, 1'b0});
        send(0, 0, 4);

        // Oversize: 10 payload flits, only the first 8 kept
        load(8'd12, 16'hC3, 64'h20, 10);
        q_a.push_back({mk_hdr(8'd12, 16'hC3), mk_data(64'h20, 8), 8'd8, 1'b1});
        send(0, 0, 12);
        chk("oversize_done", 512'(oval_a), 512'd1);

        // Undersize: header cut after two flits
        load(8'd1, 16'hD4, 64'h0, 0);
        q_a.push_back({{64'h0, 16'hD4, 48'h1, mk_h0(8'd1, 16'hD4)}, 512'h0, 8'd0, 1'b1});
        send(0, 0, 1);
        drain();

        // Reverse lane order with byte swap on the second instance
        load(8'd10, 16'h99, 64'h0, 0);
        fl[3] = 64'h0102030405060708;
        for (int i = 0; i < 7; i++) fl[4+i] = 64'hF1 + 64'(i);
        q_b.push_back({mk_hdr(8'd10, 16'h99),
                       {64'h0807060504030201, 64'hF100000000000000, 64'hF200000000000000,
                        64'hF300000000000000, 64'hF400000000000000, 64'hF500000000000000,
                        64'hF600000000000000, 64'hF700000000000000}, 8'd8, 1'b0});
        send(1, 0, 10);
        drain();

        // Backpressure: two packets buffered, third blocked until one pop
        ordy_a = 1'b0;
        load(8'd10, 16'hE1, 64'h30, 8);
        q_a.push_back({mk_hdr(8'd10, 16'hE1), mk_data(64'h30, 8), 8'd8, 1'b0});
        send(0, 0, 10);
        load(8'd10, 16'hE2, 64'h40, 8);
        q_a.push_back({mk_hdr(8'd10, 16'hE2), mk_data(64'h40, 8), 8'd8, 1'b0});
        send(0, 0, 10);
        load(8'd10, 16'hE3, 64'h50, 8);
        q_a.push_back({mk_hdr(8'd10, 16'hE3), mk_data(64'h50, 8), 8'd8, 1'b0});
        f_a = fl[0];
        v_a = 1'b1;
        chk("both_full_rdy", 512'(rdy_a), 512'd0);
        ordy_a = 1'b1;
        @(negedge clk);
        ordy_a = 1'b0;
        chk("pop_frees_rdy", 512'(rdy_a), 512'd1);
        send(0, 0, 10);
        ordy_a = 1'b1;
        drain();

        // Reset mid-packet: partial packet discarded, next packet intact
        load(8'd10, 16'hF1, 64'h60, 8);
        send(0, 0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_val_1", 512'(oval_a), 512'd0);
        @(negedge clk);
        chk("midrst_out_val_2", 512'(oval_a), 512'd0);
        rst_n = 1'b1;
        load(8'd10, 16'hF2, 64'h70, 8);
        q_a.push_back({mk_hdr(8'd10, 16'hF2), mk_data(64'h70, 8), 8'd8, 1'b0});
        send(0, 0, 10);
        drain();
        repeat (5) @(negedge clk);
        finish_run();
    end
endmodule

// File: doc/noc_axi4_bridge_deser_pp.md
Name: noc_axi4_bridge_deser_pp

Overview:
- Parametrised, double-buffered NoC-to-AXI deserializer in the chipset NoC/AXI4 bridge.
- Collects a NoC packet (header flits plus payload flits) into one wide header word and one AXI-width data word, then presents them with a valid/ready handshake.
- Two packet slots in ping-pong arrangement, so the next packet streams in while the previous one waits on out_rdy.
- Adds zero-fill of short packets, detection of oversize and undersize packets, and optional per-flit byte swap.

Parameters:
- NOC_W, 64: NoC flit width in bits.
- AXI_W, 512: AXI data width in bits. Must be a multiple of NOC_W. PAYLOAD = AXI_W/NOC_W.
- HDR_FLITS, 3: number of header flits per packet (1..4).
- LEN_W, 8: width of the message-length field.
- LEN_LSB, 22: bit position of the length field LSB in the first flit.
- DESER_ORDER, 0: 0 = first payload flit goes to lane 0 (bits [NOC_W-1:0]); 1 = first payload flit goes to lane PAYLOAD-1.
- SWAP_ENDIANESS, 0: 1 = reverse byte order inside every payload flit before storing it.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flit_in  in  NOC_W  incoming NoC flit
- flit_in_val  in  1  flit valid
- flit_in_rdy  out  1  flit accepted when val & rdy
- phy_init_done  in  1  memory PHY ready; gates flit_in_rdy
- header_out  out  HDR_FLITS*NOC_W  {hdr[HDR_FLITS-1],...,hdr[0]}, where hdr[0] is the first flit
- data_out  out  AXI_W  assembled payload
- payload_cnt  out  LEN_W  number of payload flits stored, saturated at PAYLOAD
- pkt_err  out  1  packet was malformed (see Behaviour)
- out_val  out  1  slot at the read pointer is full
- out_rdy  in  1  consumer accepts the packet when out_val & out_rdy

Behaviour:
- Storage: two slots. Each slot holds header, data, payload_cnt, err and a full flag. Pointers: wr_ptr (fill side) and rd_ptr (drain side).
- flit_in_rdy = phy_init_done & ~full[wr_ptr]. It is purely combinational; it does not depend on flit_in_val.
- Fill FSM states: HDR, DATA, DROP.
- HDR state:
  - On the first accepted flit, load remaining = flit_in[LEN_LSB+:LEN_W] and clear the slot (header and data to 0, cnt 0, err 0). This first flit is the only one where clearing happens in the same cycle.
  - Each accepted header flit k is stored into hdr[k].
  - Packet end: a flit is accepted while remaining==0. Otherwise decrement remaining on each accepted flit.
  - If the packet ends before HDR_FLITS flits arrive: the missing header flits stay 0, err=1, and the slot completes.
  - After the HDR_FLITS-th flit with remaining>0: go to DATA.
- DATA state:
  - The i-th accepted payload flit is stored at lane i (DESER_ORDER=0) or lane PAYLOAD-1-i (DESER_ORDER=1), byte-swapped if SWAP_ENDIANESS=1. Increment cnt.
  - Unwritten lanes remain 0.
  - If a payload flit arrives when cnt==PAYLOAD: go to DROP and set err. The flit is discarded.
- DROP state: accept and discard flits until packet end.
- Storage writes happen only on flit_in_val & flit_in_rdy.
- Completion: on the cycle the last flit is accepted, set full[wr_ptr] and toggle wr_ptr, then return to HDR. out_val rises the next cycle, so latency from last flit to out_val is 1 cycle.
- Drain side:
  - out_val = full[rd_ptr]. header_out, data_out, payload_cnt and pkt_err are driven from slot rd_ptr.
  - On out_val & out_rdy: clear full[rd_ptr] and toggle rd_ptr. Outputs are stable while out_val=1 and out_rdy=0.
- Simultaneous events:
  - Completion and pop in the same cycle operate on different slots; both take effect.
  - With both slots full, flit_in_rdy=0 until a pop. The pop frees the slot in the same edge, so flit_in_rdy rises the next cycle.
  - Back-to-back packets with out_rdy held at 1 run with no bubble cycles on flit_in_rdy.
- phy_init_done=0: flit_in_rdy=0. The fill FSM holds its state, including mid-packet.
- Reset:
  - Both slots are emptied and zeroed; pointers, FSM and remaining are cleared.
  - out_val=0, header_out=0, data_out=0, payload_cnt=0, pkt_err=0, flit_in_rdy=phy_init_done.
  - Reset mid-packet discards the partial packet. There is no resynchronisation: the next accepted flit is treated as a first flit.

Test Plan:
- NOC_W=64, AXI_W=512, HDR_FLITS=3, length=10, payload flits 0x10..0x17, out_rdy=1 -> out_val one cycle after the last flit; data_out lane0=0x10 ... lane7=0x17; payload_cnt=8; pkt_err=0; header_out matches the 3 header flits.
- Same packet with DESER_ORDER=1 and SWAP_ENDIANESS=1, payload flit 0x0102030405060708 first -> lane7=0x0807060504030201.
- length=4 (2 payload flits 0xAA, 0xBB) -> lane0=0xAA, lane1=0xBB, lanes 2..7=0, payload_cnt=2, pkt_err=0.
- length=12 (10 payload flits) -> all 13 flits accepted; lanes hold the first 8; payload_cnt=8; pkt_err=1. length=1 -> hdr[2]=0, payload_cnt=0, pkt_err=1.
- out_rdy=0 with three 11-flit packets sent -> two packets buffered; flit_in_rdy=0 on the first flit of the third. Raise out_rdy for 1 cycle -> packet 1 popped, flit_in_rdy=1 the next cycle, packets delivered in order 1,2,3.
- rst_n low after 5 flits of a packet, then a full packet -> out_val=0 during reset; only the second packet is delivered, intact.
